// File: rtl/uart_pkg.sv
// Shared encodings for the memory-mapped UART transmitter: FSM states,
// register select values and status register bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    localparam int ST_FULL    = 0;
    localparam int ST_IDLE    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/uart_tx_io_if.sv
// CPU IO bus as seen by the UART transmitter: strobes, register select and data.
interface uart_tx_io_if;
    logic        io_wen;
    logic        io_ren;
    logic        io_sel;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_wen, io_ren, io_sel, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_wen, io_ren, io_sel, io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for serialization. The head
// entry is readable combinationally so the FSM can load it on the pop edge.
module uart_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, the FSM
// shifts them out LSB first on tx; a status register reports full/idle/overflow/count.
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clock,
    input  logic           rst_n,
    uart_tx_io_if.slave    bus,
    output logic           tx,
    output logic           tx_busy,
    output logic           fifo_full
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t     state_reg;
    logic [15:0]   baud_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          overflow_reg;

    logic          wr_data;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          bit_done;
    logic          idle;
    logic [31:0]   status;
    logic          unused_wdata;

    assign wr_data  = bus.io_wen && (bus.io_sel == REG_DATA);
    assign push     = wr_data && !fifo_full;
    assign pop      = (state_reg == IDLE) && !fifo_empty;
    assign bit_done = (baud_reg == BIT_LAST);
    assign idle     = fifo_empty && (state_reg == IDLE);

    assign tx       = tx_reg;
    assign tx_busy  = !idle;

    assign unused_wdata = ^bus.io_wdata[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (bus.io_wdata[7:0]),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A write that hits a full FIFO wins over a same-cycle status-read clear.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (wr_data && fifo_full) begin
            overflow_reg <= 1'b1;
        end else if (bus.io_ren && (bus.io_sel == REG_STAT)) begin
            overflow_reg <= 1'b0;
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_FULL]            = fifo_full;
        status[ST_IDLE]            = idle;
        status[ST_OVF]             = overflow_reg;
        status[ST_CNT_LSB +: 4]    = 4'(count);
    end

    assign bus.io_rdata = (bus.io_sel == REG_STAT) ? status : 32'h0;

    // tx is registered from the current state, so the line lags the FSM by
    // one cycle; this yields the single idle-high cycle between frames.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg      <= 1'b1;
                    baud_reg    <= '0;
                    bit_idx_reg <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= head;
                        state_reg <= START;
                    end
                end
                START: begin
                    tx_reg <= 1'b0;
                    if (bit_done) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                DATA: begin
                    tx_reg <= shift_reg[0];
                    if (bit_done) begin
                        baud_reg  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_done) begin
                        baud_reg  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_io.md
Name: uart_tx_io

Overview:
- Memory-mapped UART transmitter peripheral on the CPU IO bus.
- CPU stores bytes to the TX data register; bytes are queued in a small FIFO and serialized 8N1, LSB first, on `tx`.
- Gives the CPU a serial output channel back to the host, the opposite direction of the UART programmer's receive path.
- The block's `tx` output is muxed with the programmer's tx at top level; that mux is not part of this block.

Parameters:
- CLKS_PER_BIT, 200, clock cycles per UART bit (23 MHz / 115200 ≈ 200); legal range 2..65535.
- FIFO_DEPTH, 8, TX FIFO entries; legal values 2, 4, 8.

Ports:
- clock  in  1  system clock (CPU clock domain)
- rst_n  in  1  reset; asynchronous assert, active-low
- io_wen  in  1  single-cycle IO write strobe
- io_ren  in  1  single-cycle IO read strobe
- io_sel  in  1  register select: 0 = TX data, 1 = status
- io_wdata  in  32  write data; only bits [7:0] are used
- io_rdata  out  32  read data, combinational from io_sel
- tx  out  1  serial output, idle high
- tx_busy  out  1  high when the FIFO is non-empty or a frame is in progress
- fifo_full  out  1  FIFO count == FIFO_DEPTH

Behaviour:
- Clock and reset: one clock, `clock`; reset `rst_n` is asynchronous, active-low.
- Reset values (asynchronous, immediate, including mid-frame):
  - tx=1, tx_busy=0, fifo_full=0
  - FIFO empty, pointers and count 0
  - overflow=0, FSM=IDLE, baud counter 0, bit index 0
  - io_rdata tracks io_sel: data reg reads 0, status reads 0x02.
- Write path:
  - io_wen=1 with io_sel=0 pushes io_wdata[7:0] if count < FIFO_DEPTH, judged before the edge.
  - If full, the byte is dropped and sticky overflow is set. This holds even if a pop happens in the same cycle.
  - io_wen with io_sel=1 is ignored.
- Status register layout (io_sel=1):
  - bit0 fifo_full
  - bit1 idle (FIFO empty and FSM IDLE)
  - bit2 overflow
  - bits[7:4] FIFO count
  - all other bits 0
- Overflow clear: io_ren=1 with io_sel=1 clears overflow at that edge. If an overflowing write lands in the same cycle, set wins.
- Data register read (io_sel=0) returns 0.
- FSM states IDLE, START, DATA, STOP. The baud counter runs 0..CLKS_PER_BIT-1; bit time ends when counter == CLKS_PER_BIT-1.
  - IDLE: tx=1. If count != 0, pop the head into the shift register and go to START at the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency: with FIFO empty and FSM IDLE, io_wen sampled at edge k makes tx fall at edge k+2.
- Frame timing:
  - Frame = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 idle-high cycle between the stop bit and the next start bit.
- Simultaneous push and pop on a non-full FIFO: both occur; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- tx is driven directly from a flop (no glitches).

Decomposition:
- uart_pkg holds:
  - FSM state encoding: 2-bit, IDLE=0, START=1, DATA=2, STOP=3
  - register select values: REG_DATA=0, REG_STAT=1
  - status bit indices: ST_FULL=0, ST_IDLE=1, ST_OVF=2, ST_CNT_LSB=4
- One sub-module, uart_tx_fifo: synchronous FIFO with push/pop/count/full/empty and async active-low reset. The FSM, baud counter and register interface stay in uart_tx_io.

Test Plan (simulation uses CLKS_PER_BIT=4, FIFO_DEPTH=8):
- Single byte: reset, then write 0xA5 at edge k -> tx=0 from edge k+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop 1 for 4 cycles. tx_busy falls at the end of the stop bit. Status reads 0x02 afterwards.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles -> two frames 41 cycles apart start-to-start (1 idle cycle gap). Status count reads 0x10 then 0x00 as the bytes are popped.
- Overflow: while the first frame transmits, write 9 more bytes so the 9th is dropped -> fifo_full=1 and status=0x85 (count 8, overflow 1, full 1). Read status -> overflow clears, next read shows 0x81. Only the 8 queued bytes are transmitted, in order.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 immediately and FIFO empty. After release, status=0x02 and no further frame is sent.
- Same-cycle events:
  - Push while the FSM pops the last byte -> count stays 1 and the new byte is sent next.
  - Status read coincident with an overflowing write -> overflow stays 1.
- Wrap-around: stream 20 bytes 0x01..0x14, writing only while fifo_full=0 -> all 20 received in order with no overflow.
